// File: rtl/board_ram_writer.sv
// Write-side owner of a 10x10 board RAM: CLEAR, PLACE (bounds + collision check) and SHOT commands.
// Registered RAM outputs; RAM read data arrives one cycle after the address.
module board_ram_writer #(
  parameter int GRID    = 10,
  parameter int ADDR_W  = 10,
  parameter int LEN_MIN = 2,
  parameter int LEN_MAX = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_x,
  input  logic [3:0]        cmd_y,
  input  logic [2:0]        cmd_len,
  input  logic              cmd_vert,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [1:0]        ram_wdata,
  input  logic [1:0]        ram_rdata,
  output logic              done,
  output logic [2:0]        status
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_CHK, S_CHK_LAST, S_WR, S_SHOT_RD, S_SHOT_WAIT, S_SHOT_WR, S_DONE
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'd0, OP_PLACE = 2'd1, OP_SHOT = 2'd2;
  localparam logic [1:0] T_EMPTY = 2'd0, T_HIT = 2'd1, T_MISS = 2'd2, T_SHIP = 2'd3;
  localparam logic [2:0] ST_OK = 3'd0, ST_HIT = 3'd1, ST_MISS = 3'd2, ST_REPEAT = 3'd3,
                         ST_COLLIDE = 3'd4, ST_BOUNDS = 3'd5, ST_BADOP = 3'd6;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d, step_q, step_d;
  logic                we_q, we_d, done_q, done_d, collide_q, collide_d;
  logic [1:0]          wdata_q, wdata_d;
  logic [2:0]          status_q, status_d, res_q, res_d, len_q, len_d, cnt_q, cnt_d;

  logic [ADDR_W-1:0]   cmd_base;
  logic [4:0]          ship_end;
  logic                xy_oob, place_oob;

  assign cmd_base  = ADDR_W'(cmd_x) + ADDR_W'(cmd_y) * ADDR_W'(GRID);
  assign ship_end  = 5'(cmd_vert ? cmd_y : cmd_x) + 5'(cmd_len) - 5'd1;
  assign xy_oob    = (cmd_x > 4'(GRID - 1)) || (cmd_y > 4'(GRID - 1));
  assign place_oob = xy_oob || (cmd_len < 3'(LEN_MIN)) || (cmd_len > 3'(LEN_MAX)) ||
                     (ship_end > 5'(GRID - 1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    base_d    = base_q;
    step_d    = step_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    wdata_d   = wdata_q;
    status_d  = status_q;
    res_d     = res_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    collide_d = collide_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        case (cmd_op)
          OP_CLEAR: begin
            state_d = S_CLR;
            addr_d  = '0;
            we_d    = 1'b1;
            wdata_d = T_EMPTY;
          end
          OP_PLACE: if (place_oob) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = ST_BOUNDS;
          end else begin
            state_d   = S_CHK;
            addr_d    = cmd_base;
            base_d    = cmd_base;
            step_d    = cmd_vert ? ADDR_W'(GRID) : ADDR_W'(1);
            len_d     = cmd_len;
            cnt_d     = 3'd1;
            collide_d = 1'b0;
          end
          OP_SHOT: if (xy_oob) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = ST_BOUNDS;
          end else begin
            state_d = S_SHOT_RD;
            addr_d  = cmd_base;
          end
          default: begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = ST_BADOP;
          end
        endcase
      end
      S_CLR: if (addr_q == ADDR_W'(GRID * GRID - 1)) begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        status_d = ST_OK;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        we_d   = 1'b1;
      end
      S_CHK: begin
        // The first check cycle sees stale read data from before the command.
        if (cnt_q != 3'd1) collide_d = collide_q | (ram_rdata != T_EMPTY);
        if (cnt_q == len_q) begin
          state_d = S_CHK_LAST;
        end else begin
          addr_d = addr_q + step_q;
          cnt_d  = cnt_q + 3'd1;
        end
      end
      S_CHK_LAST: if (collide_q || (ram_rdata != T_EMPTY)) begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        status_d = ST_COLLIDE;
      end else begin
        state_d = S_WR;
        addr_d  = base_q;
        we_d    = 1'b1;
        wdata_d = T_SHIP;
        cnt_d   = 3'd1;
      end
      S_WR: if (cnt_q == len_q) begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        status_d = ST_OK;
      end else begin
        addr_d = addr_q + step_q;
        cnt_d  = cnt_q + 3'd1;
        we_d   = 1'b1;
      end
      S_SHOT_RD: state_d = S_SHOT_WAIT;
      S_SHOT_WAIT: begin
        state_d = S_SHOT_WR;
        case (ram_rdata)
          T_SHIP:  begin we_d = 1'b1; wdata_d = T_HIT;  res_d = ST_HIT;  end
          T_EMPTY: begin we_d = 1'b1; wdata_d = T_MISS; res_d = ST_MISS; end
          default: res_d = ST_REPEAT;
        endcase
      end
      S_SHOT_WR: begin
        state_d  = S_DONE;
        done_d   = 1'b1;
        status_d = res_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      base_q    <= '0;
      step_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      wdata_q   <= 2'd0;
      status_q  <= 3'd0;
      res_q     <= 3'd0;
      len_q     <= 3'd0;
      cnt_q     <= 3'd0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      step_q    <= step_d;
      we_q      <= we_d;
      done_q    <= done_d;
      wdata_q   <= wdata_d;
      status_q  <= status_d;
      res_q     <= res_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      collide_q <= collide_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign ram_addr  = addr_q;
  assign ram_we    = we_q;
  assign ram_wdata = wdata_q;
  assign done      = done_q;
  assign status    = status_q;

endmodule

// File: doc/board_ram_writer.md
Name: board_ram_writer

Overview:
- Write-side owner of the per-player 10x10 board RAMs that the display path reads.
- Accepts single commands from the game controller: CLEAR board, PLACE ship, or SHOT at a tile.
- Performs bounds checks and collision/repeat checks by reading the RAM, then writes the 2-bit tile codes and reports a status.
- Tile codes: EMPTY=0, HIT=1, MISS=2, SHIP=3.
- Addressing is row-major: addr = x + 10*y, so tile (x,y) sits at 0..99.

Parameters:
- GRID, 10, tiles per row and per column.
- ADDR_W, 10, RAM address width.
- LEN_MIN, 2, minimum ship length.
- LEN_MAX, 5, maximum ship length.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle and able to accept a command
- cmd_op  in  2  0=CLEAR, 1=PLACE, 2=SHOT, 3=reserved
- cmd_x  in  4  column 0..9
- cmd_y  in  4  row 0..9
- cmd_len  in  3  ship length (PLACE only)
- cmd_vert  in  1  1 = ship extends +y, 0 = ship extends +x (PLACE only)
- ram_addr  out  ADDR_W  board RAM address, used for reads and writes
- ram_we  out  1  write enable
- ram_wdata  out  2  tile code to write
- ram_rdata  in  2  RAM read data, valid 1 cycle after ram_addr
- done  out  1  single-cycle completion pulse
- status  out  3  result, valid while done=1 and held until the next done

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, done=0, status=0.
- cmd_ready = (state==IDLE), so it is 1 on the first cycle after rst deasserts.
- Handshake:
  - A command is accepted on a clk edge with cmd_valid & cmd_ready ("cycle 0").
  - All cmd_* fields are captured at acceptance.
  - cmd_ready stays low until the cycle after done.
- Status codes: 0=OK, 1=HIT, 2=MISS, 3=REPEAT, 4=COLLIDE, 5=BOUNDS, 6=BADOP.
- BADOP (op=3): done in cycle 1, status 6, no RAM access.
- CLEAR:
  - ram_we=1, wdata=EMPTY, addr 0..99, in cycles 1..100.
  - done in cycle 101, status OK.
- PLACE, bounds check:
  - BOUNDS if cmd_len<LEN_MIN or cmd_len>LEN_MAX, or x>9 or y>9.
  - BOUNDS if the ship end exceeds 9 (vert: y+len-1; horizontal: x+len-1).
  - BOUNDS gives done in cycle 1 with status 5, and no RAM access.
- PLACE, check phase:
  - Read addresses issued in cycles 1..len, ram_we=0.
  - Tiles stepped by +1 (horizontal) or +10 (vert).
  - ram_rdata is sampled in cycles 2..len+1.
  - Any nonzero tile sets a sticky collide flag. There is no early abort.
- PLACE, result:
  - Collide: done in cycle len+2, status 4, no writes.
  - Otherwise SHIP is written to the same addresses in cycles len+2..2len+1, then done in cycle 2len+2 with status OK.
- SHOT:
  - x>9 or y>9: done in cycle 1, status BOUNDS.
  - Otherwise: read issued in cycle 1, data sampled in cycle 2.
  - Cycle 3 by tile value:
    - SHIP: write HIT, status HIT.
    - EMPTY: write MISS, status MISS.
    - HIT or MISS: no write (ram_we=0), status REPEAT.
  - done is always in cycle 4.
- FSM states: IDLE, CLR, CHK, CHK_LAST, WR, SHOT_RD, SHOT_WAIT, SHOT_WR, DONE.
  - DONE lasts exactly one cycle (done=1), then returns to IDLE.
- Address arithmetic: computed at ADDR_W width with no wrap-around (bounds are guaranteed by the check). ram_addr holds its last value when idle.
- Coverage: ram_we is never asserted outside the CLR, WR and SHOT_WR write cycles.
- cmd_valid while busy is ignored and not queued.
- Reset mid-operation: the next edge forces the reset values and no further writes occur. Partially written RAM is not rolled back.

Test Plan:
- rst, then CLEAR → ram_we high for exactly 100 cycles covering addrs 0..99 with wdata=0; done in cycle 101, status 0; cmd_ready high the following cycle.
- PLACE x=2 y=3 len=4 horizontal on a clear board → reads 32,33,34,35; writes SHIP to 32..35 in cycles 6..9; done in cycle 10, status 0.
- PLACE x=4 y=1 len=3 vert over the previous ship (tile 34 occupied) → reads 14,24,34; no writes; done in cycle 5, status 4.
- PLACE x=7 y=0 len=4 horizontal → done in cycle 1, status 5, no RAM access; also len=1 → status 5.
- SHOT sequence:
  - SHOT (3,3) → write 1 to addr 33, status HIT.
  - SHOT (0,0) on EMPTY → write 2 to addr 0, status MISS.
  - SHOT (3,3) again → no write, status REPEAT.
  - Each done in cycle 4.
- Assert rst during cycle 50 of a CLEAR → ram_we=0 and done=0 from the next cycle; cmd_ready=1 after release; a new SHOT is accepted and completes normally.
